// File: rtl/bist_pkg.sv
// Shared BIST definitions: controller state encoding, default MISR taps, pattern counter width.
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bist_state_e;

  localparam logic [6:0]  MISR_TAPS_7 = 7'b1100000;
  localparam int unsigned COUNT_W     = 16;

endpackage

// File: rtl/misr_core.sv
// Multiple-input signature register: loads SEED, or shifts with feedback ^(sig & TAPS) and XORs din.
module misr_core
  import bist_pkg::*;
#(
  parameter int unsigned   W    = 7,
  parameter logic [W-1:0]  TAPS = W'(MISR_TAPS_7),
  parameter logic [W-1:0]  SEED = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic [W-1:0] sig
);

  logic fb;

  assign fb = ^(sig & TAPS);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sig <= SEED;
    end else if (load) begin
      sig <= SEED;
    end else if (shift) begin
      sig <= {sig[W-2:0], fb} ^ din;
    end
  end

endmodule

// File: rtl/bist_misr_ctrl.sv
// BIST response compactor: drives lfsr_7b enable, compacts N_PATTERNS responses, compares with GOLDEN.
// Optional BIST_XMASK_EN adds resp_mask to zero unknown response bits before compaction.
module bist_misr_ctrl
  import bist_pkg::*;
#(
  parameter int unsigned   W          = 7,
  parameter int unsigned   N_PATTERNS = 127,
  parameter logic [W-1:0]  TAPS       = W'(MISR_TAPS_7),
  parameter logic [W-1:0]  SEED       = '0,
  parameter logic [W-1:0]  GOLDEN     = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] resp,
  input  logic         resp_valid,
`ifdef BIST_XMASK_EN
  input  logic [W-1:0] resp_mask,
`endif
  output logic         lfsr_en,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [W-1:0] sig
);

  localparam logic [COUNT_W-1:0] LAST = COUNT_W'(N_PATTERNS - 1);

  bist_state_e        state, state_n;
  logic [COUNT_W-1:0] count, count_n;
  logic               done_n, pass_n;
  logic               load_c, shift_c;
  logic [W-1:0]       resp_eff, sig_nxt;

`ifdef BIST_XMASK_EN
  assign resp_eff = resp & ~resp_mask;
`else
  assign resp_eff = resp;
`endif

  // Signature after the current sample, so pass is registered on the same edge as the final shift
  assign sig_nxt = {sig[W-2:0], ^(sig & TAPS)} ^ resp_eff;

  misr_core #(
    .W    (W),
    .TAPS (TAPS),
    .SEED (SEED)
  ) u_misr (
    .clk   (clk),
    .reset (reset),
    .load  (load_c),
    .shift (shift_c),
    .din   (resp_eff),
    .sig   (sig)
  );

  always_comb begin
    state_n = state;
    count_n = count;
    done_n  = done;
    pass_n  = pass;
    load_c  = 1'b0;
    shift_c = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = RUN;
          count_n = '0;
          load_c  = 1'b1;
        end
      end
      RUN: begin
        if (resp_valid) begin
          shift_c = 1'b1;
          if (count == LAST) begin
            state_n = DONE;
            done_n  = 1'b1;
            pass_n  = (sig_nxt == GOLDEN);
          end else begin
            count_n = count + COUNT_W'(1);
          end
        end
      end
      DONE: begin
        if (start) begin
          state_n = RUN;
          count_n = '0;
          done_n  = 1'b0;
          pass_n  = 1'b0;
          load_c  = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        count_n = '0;
        done_n  = 1'b0;
        pass_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      count   <= '0;
      lfsr_en <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
    end else begin
      state   <= state_n;
      count   <= count_n;
      lfsr_en <= (state_n == RUN);
      busy    <= (state_n == RUN);
      done    <= done_n;
      pass    <= pass_n;
    end
  end

endmodule

// File: tb/tb_bist_misr_ctrl.sv
// Bench for bist_misr_ctrl: four configurations share stimulus and are checked every cycle against a run-level model.
module tb_bist_misr_ctrl;

  localparam int unsigned ND = 4;
  localparam int unsigned NP [ND] = '{1, 2, 127, 2};
  localparam logic [6:0]  SD [ND] = '{7'h00, 7'h00, 7'h00, 7'h55};
  localparam logic [6:0]  GD [ND] = '{7'h00, 7'h00, 7'h00, 7'h55};

  logic       clk;
  logic       reset;
  logic       start;
  logic [6:0] resp;
  logic       resp_valid;
  logic [6:0] resp_mask;

  logic [ND-1:0] lfsr_w, busy_w, done_w, pass_w;
  logic [6:0]    sig_w [ND];

  int checks;
  int errors;

  bist_misr_ctrl #(.N_PATTERNS(1)) u_d0 (
    .clk(clk), .reset(reset), .start(start), .resp(resp), .resp_valid(resp_valid),
`ifdef BIST_XMASK_EN
    .resp_mask(resp_mask),
`endif
    .lfsr_en(lfsr_w[0]), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .sig(sig_w[0])
  );

  bist_misr_ctrl #(.N_PATTERNS(2)) u_d1 (
    .clk(clk), .reset(reset), .start(start), .resp(resp), .resp_valid(resp_valid),
`ifdef BIST_XMASK_EN
    .resp_mask(resp_mask),
`endif
    .lfsr_en(lfsr_w[1]), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .sig(sig_w[1])
  );

  bist_misr_ctrl #(.N_PATTERNS(127)) u_d2 (
    .clk(clk), .reset(reset), .start(start), .resp(resp), .resp_valid(resp_valid),
`ifdef BIST_XMASK_EN
    .resp_mask(resp_mask),
`endif
    .lfsr_en(lfsr_w[2]), .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]), .sig(sig_w[2])
  );

  bist_misr_ctrl #(.N_PATTERNS(2), .SEED(7'h55), .GOLDEN(7'h55)) u_d3 (
    .clk(clk), .reset(reset), .start(start), .resp(resp), .resp_valid(resp_valid),
`ifdef BIST_XMASK_EN
    .resp_mask(resp_mask),
`endif
    .lfsr_en(lfsr_w[3]), .busy(busy_w[3]), .done(done_w[3]), .pass(pass_w[3]), .sig(sig_w[3])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] misr_step(input logic [6:0] s, input logic [6:0] r);
    return {s[5:0], ^(s & 7'b1100000)} ^ r;
  endfunction

  // Run-level model: a run is active once started; it has collected m_cnt samples folded into m_sig
  bit         m_started [ND];
  int         m_cnt     [ND];
  logic [6:0] m_sig     [ND];

  always @(posedge clk or negedge reset) begin
    for (int i = 0; i < ND; i++) begin
      if (!reset) begin
        m_started[i] = 1'b0;
        m_cnt[i]     = 0;
        m_sig[i]     = SD[i];
      end else if (start && (!m_started[i] || m_cnt[i] == int'(NP[i]))) begin
        m_started[i] = 1'b1;
        m_cnt[i]     = 0;
        m_sig[i]     = SD[i];
      end else if (m_started[i] && m_cnt[i] < int'(NP[i]) && resp_valid) begin
        m_sig[i] = misr_step(m_sig[i], resp & ~resp_mask);
        m_cnt[i] = m_cnt[i] + 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < ND; i++) begin
      logic exp_busy, exp_done;
      exp_busy = m_started[i] && m_cnt[i] < int'(NP[i]);
      exp_done = m_started[i] && m_cnt[i] == int'(NP[i]);
      check($sformatf("d%0d_lfsr_en", i), 32'(lfsr_w[i]), 32'(exp_busy));
      check($sformatf("d%0d_busy", i),    32'(busy_w[i]), 32'(exp_busy));
      check($sformatf("d%0d_done", i),    32'(done_w[i]), 32'(exp_done));
      check($sformatf("d%0d_pass", i),    32'(pass_w[i]), 32'(exp_done && m_sig[i] == GD[i]));
      check($sformatf("d%0d_sig", i),     32'(sig_w[i]),  32'(m_sig[i]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b0;
    start      = 1'b0;
    resp       = '0;
    resp_valid = 1'b0;
    resp_mask  = '0;
    repeat (2) tick();
    check("rst_busy",  32'(busy_w[1]), 32'h0);
    check("rst_done",  32'(done_w[0]), 32'h0);
    check("rst_sig_seed", 32'(sig_w[3]), 32'h55);
    reset = 1'b1;
    tick();

    // Single-pattern and two-pattern runs
    start = 1'b1; tick(); start = 1'b0;
    resp = 7'h01; resp_valid = 1'b1; tick();
    check("n1_sig",    32'(sig_w[0]),  32'h01);
    check("n1_done",   32'(done_w[0]), 32'h1);
    check("n1_pass",   32'(pass_w[0]), 32'h0);
    check("n2_mid_lfsr_en", 32'(lfsr_w[1]), 32'h1);
    check("s55_mid_sig", 32'(sig_w[3]), 32'h2A);
    resp = 7'h00; tick();
    resp_valid = 1'b0;
    check("n2_sig",     32'(sig_w[1]),  32'h02);
    check("n2_done",    32'(done_w[1]), 32'h1);
    check("n2_lfsr_en", 32'(lfsr_w[1]), 32'h0);
    check("s55_sig",    32'(sig_w[3]),  32'h55);
    check("s55_pass",   32'(pass_w[3]), 32'h1);
    check("n1_hold",    32'(sig_w[0]),  32'h01);

    // Gapped valid: 1,0,1
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    resp = 7'h01; resp_valid = 1'b1; tick();
    resp_valid = 1'b0; resp = 7'h7F; tick();
    check("gap_sig",  32'(sig_w[1]),  32'h01);
    check("gap_done", 32'(done_w[1]), 32'h0);
    check("gap_busy", 32'(busy_w[1]), 32'h1);
    resp = 7'h00; resp_valid = 1'b1; tick();
    resp_valid = 1'b0;
    check("gap_end_sig",  32'(sig_w[1]),  32'h02);
    check("gap_end_done", 32'(done_w[1]), 32'h1);

    // start during RUN is ignored, then reset aborts mid-run
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    resp = 7'h01; resp_valid = 1'b1; tick();
    start = 1'b1; resp = 7'h00; tick();
    start = 1'b0; resp_valid = 1'b0;
    check("ign_sig",  32'(sig_w[1]),  32'h02);
    check("ign_done", 32'(done_w[1]), 32'h1);
    reset = 1'b0;
    #1;
    check("abort_busy",    32'(busy_w[2]), 32'h0);
    check("abort_lfsr_en", 32'(lfsr_w[2]), 32'h0);
    check("abort_done",    32'(done_w[1]), 32'h0);
    check("abort_pass",    32'(pass_w[3]), 32'h0);
    check("abort_sig",     32'(sig_w[3]),  32'h55);
    tick();
    reset = 1'b1;
    tick();

    // Full 127-pattern run of zeros
    start = 1'b1; tick(); start = 1'b0;
    resp = 7'h00; resp_valid = 1'b1;
    repeat (126) tick();
    check("n127_early_done", 32'(done_w[2]), 32'h0);
    tick();
    resp_valid = 1'b0;
    check("n127_done", 32'(done_w[2]), 32'h1);
    check("n127_pass", 32'(pass_w[2]), 32'h1);
    check("n127_sig",  32'(sig_w[2]),  32'h00);

`ifdef BIST_XMASK_EN
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    resp = 7'h7F; resp_mask = 7'h7F; resp_valid = 1'b1; tick();
    resp_valid = 1'b0; resp_mask = '0;
    check("xmask_sig",  32'(sig_w[0]),  32'h00);
    check("xmask_pass", 32'(pass_w[0]), 32'h1);
`endif

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      start      = ($urandom % 16) == 0;
      resp_valid = ($urandom % 4) != 0;
      resp       = 7'($urandom);
`ifdef BIST_XMASK_EN
      resp_mask  = (($urandom % 3) == 0) ? 7'($urandom) : 7'h00;
`endif
      reset      = ($urandom % 400) != 0;
      tick();
    end
    reset = 1'b1; start = 1'b0; resp_valid = 1'b0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
